// File: rtl/pipeline_pkg.sv
// Shared scoreboard types and default widths for the decode/execute interlock.
package pipeline_pkg;

  localparam int AW_DEF = 5;
  localparam int LW_DEF = 3;
  localparam int IW_DEF = 2;

  typedef enum logic [1:0] {
    STALL_NONE = 2'd0,
    STALL_RAW  = 2'd1,
    STALL_WAW  = 2'd2,
    STALL_CAP  = 2'd3
  } stall_cause_e;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_WB      = 2'd1,
    FWD_EXE     = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/pipeline_scoreboard_sb_entry.sv
// One tracked register: outstanding-write count plus countdown to bypass availability.
module sb_entry
  import pipeline_pkg::*;
#(
  parameter int LW = LW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [LW-1:0] i_lat_m1,
  input  logic          i_retire,
  output logic [IW-1:0] o_outst,
  output logic [LW-1:0] o_cnt
);

  logic [IW-1:0] r_outst;
  logic [LW-1:0] r_cnt;
  logic          w_ret;

  // Retire against an empty entry is dropped so the count never wraps.
  assign w_ret = i_retire & (r_outst != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outst <= '0;
      r_cnt   <= '0;
    end else begin
      if (i_load)
        r_cnt <= i_lat_m1;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - LW'(1);

      if (i_load && !w_ret)
        r_outst <= r_outst + IW'(1);
      else if (!i_load && w_ret)
        r_outst <= r_outst - IW'(1);
    end
  end

  assign o_outst = r_outst;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/pipeline_scoreboard.sv
// Register scoreboard and issue-stall controller between decode and execute.
// Define PIPELINE_SCOREBOARD_STATS_EN to add saturating per-cause stall counters.
module pipeline_scoreboard
  import pipeline_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int AW           = AW_DEF,
  parameter int MAX_LAT      = 4,
  parameter int LW           = LW_DEF,
  parameter int MAX_INFLIGHT = 3,
  parameter int IW           = IW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rs,
  input  logic          issue_rs_used,
  input  logic [AW-1:0] issue_rt,
  input  logic          issue_rt_used,
  input  logic          issue_wr,
  input  logic [AW-1:0] issue_rd,
  input  logic [LW-1:0] issue_lat,
  input  logic          flush,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd,
  output logic          issue_stall,
  output logic          issue_fire,
  output logic          fwd_a_hit,
  output logic          fwd_b_hit,
  output logic [LW+1:0] inflight
`ifdef PIPELINE_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]   stat_raw,
  output logic [31:0]   stat_waw,
  output logic [31:0]   stat_cap
`endif
);

  localparam logic [LW-1:0] MAX_LAT_L = LW'(MAX_LAT);
  localparam logic [IW-1:0] MAX_INF_L = IW'(MAX_INFLIGHT);

  logic [NUM_REGS-1:0][IW-1:0] w_outst;
  logic [NUM_REGS-1:0][LW-1:0] w_cnt;
  logic [LW-1:0] w_lat_e;
  logic [LW-1:0] w_lat_m1;
  logic          w_a_pend, w_b_pend;
  logic          w_raw, w_waw, w_cap, w_any;
  logic          w_live, w_wr_fire, w_retire;
  logic [LW+1:0] r_inflight;

  always_comb begin
    w_lat_e = issue_lat;
    if (issue_lat == '0)
      w_lat_e = LW'(1);
    else if (issue_lat > MAX_LAT_L)
      w_lat_e = MAX_LAT_L;
  end
  assign w_lat_m1 = w_lat_e - LW'(1);

  assign w_a_pend = issue_rs_used & (issue_rs != '0) & (w_outst[issue_rs] != '0);
  assign w_b_pend = issue_rt_used & (issue_rt != '0) & (w_outst[issue_rt] != '0);

  assign w_raw = (w_a_pend & (w_cnt[issue_rs] != '0)) | (w_b_pend & (w_cnt[issue_rt] != '0));
  // A younger write may not land before an older one to the same register.
  assign w_waw = issue_wr & (w_outst[issue_rd] != '0) & (w_cnt[issue_rd] > w_lat_m1);
  assign w_cap = issue_wr & (w_outst[issue_rd] == MAX_INF_L);
  assign w_any = w_raw | w_waw | w_cap;

  assign w_live      = issue_valid & ~flush & ~reset;
  assign issue_stall = w_live & w_any;
  assign issue_fire  = w_live & ~w_any;
  assign fwd_a_hit   = ~reset & w_a_pend & (w_cnt[issue_rs] == '0);
  assign fwd_b_hit   = ~reset & w_b_pend & (w_cnt[issue_rt] == '0);

  assign w_wr_fire = issue_fire & issue_wr & (issue_rd != '0);
  assign w_retire  = wb_valid & (wb_rd != '0) & (w_outst[wb_rd] != '0);

  assign w_outst[0] = '0;
  assign w_cnt[0]   = '0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_entry
      sb_entry #(
        .LW (LW),
        .IW (IW)
      ) u_entry (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_wr_fire && (issue_rd == AW'(gi))),
        .i_lat_m1 (w_lat_m1),
        .i_retire (wb_valid && (wb_rd == AW'(gi))),
        .o_outst  (w_outst[gi]),
        .o_cnt    (w_cnt[gi])
      );
    end
  endgenerate

  // Tracks the sum of all outstanding counts incrementally, in step with the entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_inflight <= '0;
    else
      r_inflight <= r_inflight + (LW+2)'(w_wr_fire) - (LW+2)'(w_retire);
  end
  assign inflight = r_inflight;

`ifdef PIPELINE_SCOREBOARD_STATS_EN
  logic [31:0] r_stat_raw, r_stat_waw, r_stat_cap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_raw <= '0;
      r_stat_waw <= '0;
      r_stat_cap <= '0;
    end else begin
      if (w_live && w_raw && (r_stat_raw != '1)) r_stat_raw <= r_stat_raw + 32'd1;
      if (w_live && w_waw && (r_stat_waw != '1)) r_stat_waw <= r_stat_waw + 32'd1;
      if (w_live && w_cap && (r_stat_cap != '1)) r_stat_cap <= r_stat_cap + 32'd1;
    end
  end

  assign stat_raw = r_stat_raw;
  assign stat_waw = r_stat_waw;
  assign stat_cap = r_stat_cap;
`endif

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Self-checking bench: timestamp-based scoreboard model, directed scenarios, random traffic.
module tb_pipeline_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_rs_used, issue_rt_used, issue_wr, flush, wb_valid;
  logic [4:0] issue_rs, issue_rt, issue_rd, wb_rd;
  logic [2:0] issue_lat;
  logic       issue_stall, issue_fire, fwd_a_hit, fwd_b_hit;
  logic [4:0] inflight;
`ifdef PIPELINE_SCOREBOARD_STATS_EN
  logic [31:0] stat_raw, stat_waw, stat_cap;
`endif

  always #5 clk = ~clk;

  pipeline_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_rs      (issue_rs),
    .issue_rs_used (issue_rs_used),
    .issue_rt      (issue_rt),
    .issue_rt_used (issue_rt_used),
    .issue_wr      (issue_wr),
    .issue_rd      (issue_rd),
    .issue_lat     (issue_lat),
    .flush         (flush),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .issue_stall   (issue_stall),
    .issue_fire    (issue_fire),
    .fwd_a_hit     (fwd_a_hit),
    .fwd_b_hit     (fwd_b_hit),
    .inflight      (inflight)
`ifdef PIPELINE_SCOREBOARD_STATS_EN
    ,
    .stat_raw      (stat_raw),
    .stat_waw      (stat_waw),
    .stat_cap      (stat_cap)
`endif
  );

  int tests = 0;
  int fails = 0;
  int now_c = 0;
  int ready_m [32];   // cycle at which the newest result of each register is on the bypass
  int outst_m [32];   // outstanding writes per register
  logic       c_stall, c_fire, c_fa, c_fb;
  logic [4:0] c_inf;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, now_c);
    end
  endtask

  function automatic int rem(input int r);
    return (ready_m[r] > now_c) ? ready_m[r] - now_c : 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      ready_m[i] = 0;
      outst_m[i] = 0;
    end
  endtask

  task automatic step(input logic v, input logic [4:0] rs, input logic rsu,
                      input logic [4:0] rt, input logic rtu, input logic wr,
                      input logic [4:0] rd, input logic [2:0] lat, input logic fl,
                      input logic wbv, input logic [4:0] wbr);
    int   le, sum;
    logic a_p, b_p, raw, waw, cap, e_stall, e_fire, e_fa, e_fb, ret;
    @(negedge clk);
    issue_valid = v;   issue_rs = rs; issue_rs_used = rsu;
    issue_rt = rt;     issue_rt_used = rtu;
    issue_wr = wr;     issue_rd = rd; issue_lat = lat;
    flush = fl;        wb_valid = wbv; wb_rd = wbr;
    #1;
    le  = (lat == 3'd0) ? 1 : ((int'(lat) > 4) ? 4 : int'(lat));
    a_p = rsu && (rs != 0) && (outst_m[rs] != 0);
    b_p = rtu && (rt != 0) && (outst_m[rt] != 0);
    raw = (a_p && rem(int'(rs)) != 0) || (b_p && rem(int'(rt)) != 0);
    waw = wr && (outst_m[rd] != 0) && (rem(int'(rd)) > le - 1);
    cap = wr && (outst_m[rd] == 3);
    e_stall = v && !fl && (raw || waw || cap);
    e_fire  = v && !fl && !(raw || waw || cap);
    e_fa    = a_p && (rem(int'(rs)) == 0);
    e_fb    = b_p && (rem(int'(rt)) == 0);
    sum = 0;
    for (int i = 0; i < 32; i++) sum += outst_m[i];
    c_stall = issue_stall; c_fire = issue_fire;
    c_fa = fwd_a_hit; c_fb = fwd_b_hit; c_inf = inflight;
    chk("stall", c_stall, e_stall);
    chk("fire", c_fire, e_fire);
    chk("fwd_a", c_fa, e_fa);
    chk("fwd_b", c_fb, e_fb);
    chk("inflight", c_inf, sum % 32);
    $display("[TB] cyc=%0d v=%0b rs=%0d/%0b rt=%0d/%0b wr=%0b rd=%0d lat=%0d fl=%0b wb=%0b/%0d -> stall=%0b fire=%0b fa=%0b fb=%0b inflight=%0d",
             now_c, v, rs, rsu, rt, rtu, wr, rd, lat, fl, wbv, wbr, c_stall, c_fire, c_fa, c_fb, c_inf);
    @(posedge clk);
    ret = wbv && (wbr != 0) && (outst_m[wbr] != 0);
    if (e_fire && wr && rd != 0) begin
      ready_m[rd] = now_c + le;
      outst_m[rd]++;
    end
    if (ret) outst_m[wbr]--;
    now_c++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd7; issue_lat = 3'd1;
    issue_rs = 5'd7; issue_rs_used = 1'b1; flush = 1'b0; wb_valid = 1'b0;
    #1;
    chk("rst_inflight", inflight, 0);
    chk("rst_fire", issue_fire, 0);
    chk("rst_stall", issue_stall, 0);
    chk("rst_fwd_a", fwd_a_hit, 0);
    $display("[TB] reset asserted at cycle %0d", now_c);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    issue_valid = 1'b0; wb_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b1; issue_rs = 5'd3; issue_rs_used = 1'b1;
    issue_rt = 5'd4; issue_rt_used = 1'b1; issue_wr = 1'b1; issue_rd = 5'd3;
    issue_lat = 3'd2; flush = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", issue_stall, 0);
    chk("reset_fire", issue_fire, 0);
    chk("reset_fwd_a", fwd_a_hit, 0);
    chk("reset_fwd_b", fwd_b_hit, 0);
    chk("reset_inflight", inflight, 0);
    @(negedge clk);
    reset = 1'b0; issue_valid = 1'b0;

    // ALU result bypassed back-to-back
    step(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
    chk("t1_first_fire", c_fire, 1);
    step(1, 3, 1, 0, 0, 1, 4, 1, 0, 0, 0);
    chk("t1_no_stall", c_stall, 0);
    chk("t1_fwd_a", c_fa, 1);
    chk("t1_inflight", c_inf, 1);

    // load-use: exactly one bubble
    step(1, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0);
    step(1, 0, 0, 5, 1, 1, 8, 1, 0, 0, 0);
    chk("t2_stall", c_stall, 1);
    step(1, 0, 0, 5, 1, 1, 8, 1, 0, 0, 0);
    chk("t2_fire", c_fire, 1);
    chk("t2_fwd_b", c_fb, 1);

    // WAW behind a 4-cycle multiply
    step(1, 0, 0, 0, 0, 1, 6, 4, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0);
      chk("t3_waw_stall", c_stall, 1);
    end
    step(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0);
    chk("t3_fire", c_fire, 1);
`ifdef PIPELINE_SCOREBOARD_STATS_EN
    #1;
    chk("t3_stat_waw", stat_waw, 3);
`endif

    // r0 is never tracked
    step(1, 0, 1, 0, 1, 1, 0, 3, 0, 0, 0);
    chk("t4_fire", c_fire, 1);
    chk("t4_fwd_a", c_fa, 0);
    chk("t4_fwd_b", c_fb, 0);

    // flush kills a stalled instruction; countdown keeps running
    step(1, 0, 0, 0, 0, 1, 9, 3, 0, 0, 0);
    step(1, 9, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("t5_flush_stall", c_stall, 0);
    chk("t5_flush_fire", c_fire, 0);
    step(1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("t5_stall", c_stall, 1);
    step(1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("t5_fire", c_fire, 1);
    chk("t5_fwd_a", c_fa, 1);

    // capacity on r7, retire same cycle, then reset mid-sequence
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
      chk("t6_fill_fire", c_fire, 1);
    end
    step(1, 0, 0, 0, 0, 1, 7, 1, 0, 1, 7);
    chk("t6_cap_stall", c_stall, 1);
    step(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
    chk("t6_cap_fire", c_fire, 1);
    do_reset();
    step(1, 7, 1, 0, 0, 1, 7, 2, 0, 0, 0);
    chk("t6_post_fire", c_fire, 1);
    chk("t6_post_fwd_a", c_fa, 0);
    chk("t6_post_inflight", c_inf, 0);

    // randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0,
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
